// File: rtl/alu_serial_ctrl_if.sv
// Handshake/bus bundle for alu_serial_ctrl.
//   start, abort : request / cancel from the requester
//   op, a, b     : operation code and operands, captured with start
//   busy         : high while bits are being sequenced
//   done         : one-cycle completion pulse
//   result       : assembled result, valid from done until next capture
interface alu_serial_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             abort;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, abort, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, abort, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Sequences an external combinational 1-bit ALU slice across WIDTH operand
// bits, LSB first, one bit per clock, assembling the result MSB-in.
//   clk, reset          : clock, asynchronous active-high reset
//   bus (slave)         : start/abort/op/a/b in, busy/done/result out
//   alu_M/alu_S1/alu_S0 : operation select to the slice (0 outside SHIFT)
//   alu_A/alu_B         : current operand bits to the slice (0 outside SHIFT)
//   alu_F               : slice output, sampled each SHIFT cycle
module alu_serial_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   alu_serial_ctrl_if.slave bus,
   output logic          alu_M,
   output logic          alu_S1,
   output logic          alu_S0,
   output logic          alu_A,
   output logic          alu_B,
   input  logic          alu_F
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         op_reg  <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // start takes priority; abort is meaningless outside SHIFT
               if (bus.start) begin
                  op_reg <= bus.op;
                  a_reg  <= bus.a;
                  b_reg  <= bus.b;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
               done_q <= 1'b0;
            end
            SHIFT: begin
               if (bus.abort) begin
                  // partial result is left in place and not flagged valid
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  res_reg <= {alu_F, res_reg[WIDTH-1:1]};
                  a_reg   <= a_reg >> 1;
                  b_reg   <= b_reg >> 1;
                  cnt     <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // slice drive comes only from registers, forced low outside SHIFT
   assign alu_M  = busy_q & op_reg[2];
   assign alu_S1 = busy_q & op_reg[1];
   assign alu_S0 = busy_q & op_reg[0];
   assign alu_A  = busy_q & a_reg[0];
   assign alu_B  = busy_q & b_reg[0];

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = res_reg;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_serial_ctrl_if #(.WIDTH(8)) bus8 ();
   alu_serial_ctrl_if #(.WIDTH(4)) bus4 ();

   logic m8, s18, s08, a8, b8, f8;
   logic m4, s14, s04, a4, b4, f4;

   // behavioural 1-bit slice stubs
   assign f8 = m8 ? (a8 ^ b8) : (s18 ? (a8 | b8) : (a8 & b8));
   assign f4 = m4 ? (a4 ^ b4) : (s14 ? (a4 | b4) : (a4 & b4));

   alu_serial_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .bus(bus8),
      .alu_M(m8), .alu_S1(s18), .alu_S0(s08), .alu_A(a8), .alu_B(b8), .alu_F(f8)
   );

   alu_serial_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4),
      .alu_M(m4), .alu_S1(s14), .alu_S0(s04), .alu_A(a4), .alu_B(b4), .alu_F(f4)
   );

   typedef struct {
      logic [31:0] res;
      int unsigned cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int unsigned w);
      logic [31:0] r;
      if (op[2])      r = a ^ b;
      else if (op[1]) r = a | b;
      else            r = a & b;
      return r & ((32'h1 << w) - 32'h1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h required %h", tag, obs, expv);
      end
   endtask

   // scoreboard: pop on every done pulse, check result and latency
   always @(negedge clk) begin
      if (!reset && bus8.done) begin
         checks++;
         assert (q8.size() != 0) else begin
            errors++;
            $error("FAIL done8_spurious: observed done=1 required no pending op");
         end
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            checks++;
            assert (bus8.result === e8.res[7:0]) else begin
               errors++;
               $error("FAIL result8: observed %h required %h", bus8.result, e8.res[7:0]);
            end
            checks++;
            assert (cyc === e8.cyc) else begin
               errors++;
               $error("FAIL latency8: observed edge %0d required edge %0d", cyc, e8.cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus4.done) begin
         checks++;
         assert (q4.size() != 0) else begin
            errors++;
            $error("FAIL done4_spurious: observed done=1 required no pending op");
         end
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            checks++;
            assert (bus4.result === e4.res[3:0]) else begin
               errors++;
               $error("FAIL result4: observed %h required %h", bus4.result, e4.res[3:0]);
            end
            checks++;
            assert (cyc === e4.cyc) else begin
               errors++;
               $error("FAIL latency4: observed edge %0d required edge %0d", cyc, e4.cyc);
            end
         end
      end
   end

   // called just after a falling edge; capture happens at the next rising edge
   task automatic start8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit expect_done);
      exp_t e;
      bus8.op = op; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
      if (expect_done) begin
         e.res = model(op, {24'h0, a}, {24'h0, b}, 8);
         e.cyc = cyc + 1 + 8;
         q8.push_back(e);
      end
   endtask

   task automatic start4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      bus4.op = op; bus4.a = a; bus4.b = b; bus4.start = 1'b1;
      e.res = model(op, {28'h0, a}, {28'h0, b}, 4);
      e.cyc = cyc + 1 + 4;
      q4.push_back(e);
   endtask

   task automatic drain8(input int unsigned limit);
      int unsigned n = 0;
      while (q8.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (q8.size() == 0) else begin
         errors++;
         $error("FAIL drain8_timeout: observed %0d pending required 0", q8.size());
         q8.delete();
      end
   endtask

   task automatic drain4(input int unsigned limit);
      int unsigned n = 0;
      while (q4.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (q4.size() == 0) else begin
         errors++;
         $error("FAIL drain4_timeout: observed %0d pending required 0", q4.size());
         q4.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] seq_a;
      logic [7:0] seq_b;
      int unsigned n;
      seq_a = 8'hA5;
      seq_b = 8'h0F;

      reset = 1'b1;
      bus8.start = 1'b0; bus8.abort = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
      bus4.start = 1'b0; bus4.abort = 1'b0; bus4.op = '0; bus4.a = '0; bus4.b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy8", bus8.busy, 1'b0);
      chk("rst_done8", bus8.done, 1'b0);
      chk("rst_result8", bus8.result, 8'h00);
      chk("rst_alu8", {m8, s18, s08, a8, b8}, 5'b0);
      chk("rst_result4", bus4.result, 4'h0);
      reset = 1'b0;
      @(negedge clk);

      // single op: xor A5 ^ 0F, bit-by-bit operand drive
      start8(3'b100, 8'hA5, 8'h0F, 1'b1);
      @(negedge clk);
      bus8.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("shift_busy", bus8.busy, 1'b1);
         chk("shift_alu_A", a8, seq_a[i]);
         chk("shift_alu_B", b8, seq_b[i]);
         chk("shift_alu_M", m8, 1'b1);
         @(negedge clk);
      end
      chk("done_busy_low", bus8.busy, 1'b0);
      chk("done_pulse", bus8.done, 1'b1);
      @(negedge clk);
      chk("idle_done_low", bus8.done, 1'b0);
      chk("idle_alu_zero", {m8, s18, s08, a8, b8}, 5'b0);
      chk("idle_result_hold", bus8.result, 8'hAA);
      drain8(4);

      // back-to-back: start held through DONE
      @(negedge clk);
      start8(3'b000, 8'hFF, 8'h3C, 1'b1);
      @(negedge clk);
      n = 0;
      while (!bus8.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_done", bus8.done, 1'b1);
      start8(3'b010, 8'h01, 8'h80, 1'b1);
      @(negedge clk);
      chk("b2b_no_bubble", bus8.busy, 1'b1);
      bus8.start = 1'b0;
      drain8(20);

      // inputs changed and start pulsed during SHIFT are ignored
      @(negedge clk);
      start8(3'b001, 8'h6C, 8'h5A, 1'b1);
      @(negedge clk);
      bus8.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus8.op = 3'b111; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
      @(negedge clk);
      bus8.a = 8'h00;
      @(negedge clk);
      bus8.op = 3'b100;
      @(negedge clk);
      bus8.start = 1'b0;
      drain8(20);
      repeat (3) @(negedge clk);

      // abort in SHIFT cycle 3
      start8(3'b110, 8'h3C, 8'h0F, 1'b0);
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      bus8.abort = 1'b1;
      @(negedge clk);
      bus8.abort = 1'b0;
      chk("abort_busy", bus8.busy, 1'b0);
      chk("abort_alu_zero", {m8, s18, s08, a8, b8}, 5'b0);
      repeat (10) @(negedge clk);
      chk("abort_no_done", bus8.done, 1'b0);
      start8(3'b110, 8'h3C, 8'h0F, 1'b1);
      @(negedge clk);
      bus8.start = 1'b0;
      drain8(20);
      repeat (2) @(negedge clk);

      // abort together with start in IDLE: start wins
      bus8.abort = 1'b1;
      start8(3'b101, 8'h55, 8'h0F, 1'b1);
      @(negedge clk);
      bus8.abort = 1'b0;
      bus8.start = 1'b0;
      chk("abort_start_busy", bus8.busy, 1'b1);
      drain8(20);
      repeat (2) @(negedge clk);

      // asynchronous reset in SHIFT cycle 5
      start8(3'b011, 8'hC3, 8'h18, 1'b0);
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_busy", bus8.busy, 1'b0);
      chk("areset_done", bus8.done, 1'b0);
      chk("areset_result", bus8.result, 8'h00);
      chk("areset_alu_zero", {m8, s18, s08, a8, b8}, 5'b0);
      bus8.op = 3'b001; bus8.a = 8'hF0; bus8.b = 8'h3C; bus8.start = 1'b1;
      @(negedge clk);
      chk("reset_hold_busy", bus8.busy, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("deassert_no_start", bus8.busy, 1'b0);
      start8(3'b001, 8'hF0, 8'h3C, 1'b1);
      @(negedge clk);
      chk("post_reset_start", bus8.busy, 1'b1);
      bus8.start = 1'b0;
      drain8(20);

      // all op codes with random operands, both widths
      for (int op = 0; op < 8; op++) begin
         for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            start8(3'(op), 8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1);
            @(negedge clk);
            bus8.start = 1'b0;
            drain8(20);
         end
      end
      for (int op = 0; op < 8; op++) begin
         for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            start4(3'(op), 4'($urandom_range(15)), 4'($urandom_range(15)));
            @(negedge clk);
            bus4.start = 1'b0;
            drain4(20);
         end
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 abort  input  1  cancels an operation in progress.
REQ-006 op  input  3  {M,S1,S0} operation code, captured with start.
REQ-007 a, b  input  WIDTH  operands, captured with start.
REQ-008 busy  output  1  high while state is SHIFT.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  WIDTH  assembled result, valid from done, held until next capture.
REQ-011 alu_M, alu_S1, alu_S0  output  1 each  operation select to the 1-bit ALU slice.
REQ-012 alu_A, alu_B  output  1 each  operand bits to the slice.
REQ-013 alu_F  input  1  combinational slice output.

Function
REQ-014 The block SHALL sequence a single combinational 1-bit ALU slice across WIDTH bits, LSB first, one bit per clock.
REQ-015 States SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-016 IDLE/DONE with start=1 at an edge: latch op, a, b into registers, clear bit counter to 0, go to SHIFT.
REQ-017 SHIFT: alu_A = a_reg[0], alu_B = b_reg[0], {alu_M,alu_S1,alu_S0} = op_reg, all driven directly from registers (no combinational path from start/a/b/op).
REQ-018 Each SHIFT edge: shift alu_F into result shift register at MSB (shift right), shift a_reg and b_reg right by one, increment counter.
REQ-019 After the edge at which the counter reaches WIDTH-1 the state SHALL go to DONE; SHIFT lasts exactly WIDTH cycles, so bit i of result equals alu_F sampled in SHIFT cycle i.
REQ-020 DONE lasts one cycle with done=1; without start it returns to IDLE; with start it re-enters SHIFT directly (back-to-back, no idle bubble).
REQ-021 Latency: start sampled at edge E0 -> done high in cycle between edges E(WIDTH) and E(WIDTH+1).
REQ-022 start while in SHIFT SHALL be ignored (no queueing); op/a/b changes during SHIFT SHALL not affect the operation.
REQ-023 abort=1 at an edge in SHIFT: go to IDLE, no done pulse, result register keeps partial contents and is not defined as valid; abort outside SHIFT has no effect.
REQ-024 abort and start together in IDLE/DONE: start wins (abort is no-op there).
REQ-025 Outside SHIFT, alu_A, alu_B, alu_M, alu_S1, alu_S0 SHALL be 0.
REQ-026 result SHALL change only during SHIFT; it holds its value in IDLE and DONE.

Reset
REQ-027 reset=1 SHALL immediately, independent of clk, force IDLE, busy=0, done=0, result=0, counter=0, op/a/b registers=0, all alu_* outputs=0.
REQ-028 reset asserted mid-SHIFT SHALL abandon the operation with no done pulse; first start after deassertion behaves per REQ-016.
REQ-029 reset deassertion SHALL not itself start an operation even if start is high; start is sampled from the first edge after deassertion.

Verification
Bench uses a behavioural slice stub: alu_F = M ? (A ^ B) : (S1 ? A | B : A & B).
REQ-030 WIDTH=8, op=3'b100, a=8'hA5, b=8'h0F, start 1 cycle -> busy for 8 cycles, done 1 cycle at E8, result=8'hAA; alu_A sequence 1,0,1,0,0,1,0,1.
REQ-031 op=3'b000, a=8'hFF, b=8'h3C, then start held high through DONE with op=3'b010, a=8'h01, b=8'h80 -> first result 8'h3C, second op starts with no idle cycle, result 8'h81.
REQ-032 Start accepted, a/b/op changed and start pulsed on cycles 2-4 of SHIFT -> result reflects originally captured values, single done pulse.
REQ-033 abort at SHIFT cycle 3 -> IDLE next cycle, done never asserts, alu_* outputs 0; new start then completes normally.
REQ-034 reset pulsed asynchronously (between edges) in SHIFT cycle 5 -> all outputs 0 immediately, no done; start held high across deassertion begins only at first post-reset edge.
REQ-035 Exhaustive: all 8 op codes x 256 random a/b pairs, WIDTH=8 and WIDTH=4 -> result matches stub applied bitwise, latency exactly WIDTH+1 edges every time.
